// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with registered, count-aligned sync/blank flags
//
// Ports:
//   pclk            in   1   pixel clock, the only clock
//   rst             in   1   synchronous active-high reset
//   hcount_out      out  11  current pixel column, 0..H_TOTAL-1
//   vcount_out      out  11  current line, 0..V_TOTAL-1
//   hsync_out       out  1   horizontal sync, active-high
//   vsync_out       out  1   vertical sync, active-high
//   hblnk_out       out  1   horizontal blanking (hcount >= H_ACTIVE)
//   vblnk_out       out  1   vertical blanking (vcount >= V_ACTIVE)
//   line_start_out  out  1   one-cycle pulse when hcount has just wrapped to 0
//   frame_start_out out  1   one-cycle pulse when (hcount,vcount) has just wrapped to (0,0)

module vga_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic        pclk,
    input  logic        rst,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        line_start_out,
    output logic        frame_start_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Thresholds are held in 12 bits so that a sync end or total of
    // exactly 2048 still compares correctly against an 11-bit count.
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_BLNK_BEG = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_BLNK_BEG = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_line_start;
    logic        r_frame_start;

    logic        w_h_last;
    logic        w_v_last;
    logic [10:0] w_hcount_nxt;
    logic [10:0] w_vcount_nxt;
    logic [11:0] w_h_nxt;
    logic [11:0] w_v_nxt;

    assign w_h_last = ({1'b0, r_hcount} == H_LAST);
    assign w_v_last = ({1'b0, r_vcount} == V_LAST);

    always_comb begin
        w_hcount_nxt = r_hcount + 11'd1;
        w_vcount_nxt = r_vcount;
        if (w_h_last) begin
            w_hcount_nxt = 11'd0;
            w_vcount_nxt = w_v_last ? 11'd0 : (r_vcount + 11'd1);
        end
    end

    assign w_h_nxt = {1'b0, w_hcount_nxt};
    assign w_v_nxt = {1'b0, w_vcount_nxt};

    // Flags are decoded from the next counts so that each registered flag
    // lands in the same cycle as the count value it describes.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_hcount      <= 11'd0;
            r_vcount      <= 11'd0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hblnk       <= (w_h_nxt >= H_BLNK_BEG);
            r_hsync       <= (w_h_nxt >= H_SYNC_BEG) && (w_h_nxt < H_SYNC_END);
            r_vblnk       <= (w_v_nxt >= V_BLNK_BEG);
            r_vsync       <= (w_v_nxt >= V_SYNC_BEG) && (w_v_nxt < V_SYNC_END);
            // Pulses come only from a real wrap, never from the reset (0,0).
            r_line_start  <= w_h_last;
            r_frame_start <= w_h_last && w_v_last;
        end
    end

    assign hcount_out      = r_hcount;
    assign vcount_out      = r_vcount;
    assign hsync_out       = r_hsync;
    assign vsync_out       = r_vsync;
    assign hblnk_out       = r_hblnk;
    assign vblnk_out       = r_vblnk;
    assign line_start_out  = r_line_start;
    assign frame_start_out = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen on a reduced raster

module tb_vga_timing_gen;

    // Reduced raster: 32 x 20 = 640 pixels per frame.
    // hblnk 16..31, hsync 20..25; vblnk 12..19, vsync 14..16.
    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BP     = 6;
    localparam int V_ACTIVE = 12;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 3;
    localparam int V_BP     = 3;
    localparam int HT       = 32;
    localparam int VT       = 20;
    localparam int FRAME    = 640;

    logic        pclk;
    logic        rst;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic        line_start_out;
    logic        frame_start_out;

    int checks;
    int errors;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .pclk           (pclk),
        .rst            (rst),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .hblnk_out      (hblnk_out),
        .vblnk_out      (vblnk_out),
        .line_start_out (line_start_out),
        .frame_start_out(frame_start_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Advance to a given position; an unreachable position counts as a failure.
    task automatic goto(input int h, input int v);
        int n;
        n = 0;
        while (!(hcount_out == 11'(h) && vcount_out == 11'(v)) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        checks++;
        if (hcount_out !== 11'(h) || vcount_out !== 11'(v)) begin
            errors++;
            $display("FAIL goto: got (%0d,%0d) required (%0d,%0d)", hcount_out, vcount_out, h, v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                 line_start_out, frame_start_out} !== 28'd0) begin
                errors++;
                $display("FAIL reset_hold: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b required all 0",
                         hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                         line_start_out, frame_start_out);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (hcount_out !== 11'(i) || vcount_out !== 11'd0 || line_start_out !== 1'b0 ||
                frame_start_out !== 1'b0 || hblnk_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_release: h=%0d v=%0d ls=%b fs=%b hb=%b required h=%0d v=0 ls=0 fs=0 hb=0",
                         hcount_out, vcount_out, line_start_out, frame_start_out, hblnk_out, i);
            end
        end
    endtask

    task automatic test_h_edges();
        int exp_hb [6] = '{0, 1, 1, 1, 1, 1};
        int exp_hs [6] = '{0, 0, 0, 1, 1, 0};
        int pos    [6] = '{15, 16, 19, 20, 25, 26};
        for (int i = 0; i < 6; i++) begin
            goto(pos[i], 0);
            checks++;
            if (hblnk_out !== exp_hb[i][0] || hsync_out !== exp_hs[i][0] || vblnk_out !== 1'b0) begin
                errors++;
                $display("FAIL h_edge@%0d: hb=%b hs=%b vb=%b required hb=%0d hs=%0d vb=0",
                         pos[i], hblnk_out, hsync_out, vblnk_out, exp_hb[i], exp_hs[i]);
            end
        end
    endtask

    task automatic test_line_wrap();
        goto(31, 10);
        checks++;
        if (line_start_out !== 1'b0 || hblnk_out !== 1'b1) begin
            errors++;
            $display("FAIL line_pre: ls=%b hb=%b required ls=0 hb=1", line_start_out, hblnk_out);
        end
        tick();
        checks++;
        if (hcount_out !== 11'd0 || vcount_out !== 11'd11 || line_start_out !== 1'b1 ||
            frame_start_out !== 1'b0 || hblnk_out !== 1'b0) begin
            errors++;
            $display("FAIL line_wrap: h=%0d v=%0d ls=%b fs=%b hb=%b required h=0 v=11 ls=1 fs=0 hb=0",
                     hcount_out, vcount_out, line_start_out, frame_start_out, hblnk_out);
        end
        tick();
        checks++;
        if (hcount_out !== 11'd1 || line_start_out !== 1'b0) begin
            errors++;
            $display("FAIL line_pulse_len: h=%0d ls=%b required h=1 ls=0", hcount_out, line_start_out);
        end
    endtask

    task automatic test_frame_wrap();
        goto(31, 19);
        checks++;
        if (vblnk_out !== 1'b1 || vsync_out !== 1'b0 || frame_start_out !== 1'b0) begin
            errors++;
            $display("FAIL frame_pre: vb=%b vs=%b fs=%b required vb=1 vs=0 fs=0",
                     vblnk_out, vsync_out, frame_start_out);
        end
        tick();
        checks++;
        if (hcount_out !== 11'd0 || vcount_out !== 11'd0 || line_start_out !== 1'b1 ||
            frame_start_out !== 1'b1 || vblnk_out !== 1'b0 || vsync_out !== 1'b0) begin
            errors++;
            $display("FAIL frame_wrap: h=%0d v=%0d ls=%b fs=%b vb=%b vs=%b required 0 0 1 1 0 0",
                     hcount_out, vcount_out, line_start_out, frame_start_out, vblnk_out, vsync_out);
        end
    endtask

    // Starts on the frame_start cycle; walks one full frame against an
    // independent position model and counts pulses.
    task automatic test_frame_period();
        int eh, ev, n_ls, n_fs, k;
        logic [27:0] exp_v, got_v;
        logic e_hb, e_hs, e_vb, e_vs, e_ls, e_fs;
        n_ls = 0;
        n_fs = 0;
        for (k = 0; k < FRAME; k++) begin
            eh   = k % HT;
            ev   = k / HT;
            e_hb = (eh >= 16);
            e_hs = (eh >= 20 && eh <= 25);
            e_vb = (ev >= 12);
            e_vs = (ev >= 14 && ev <= 16);
            e_ls = (eh == 0);
            e_fs = (eh == 0 && ev == 0);
            exp_v = {11'(eh), 11'(ev), e_hs, e_vs, e_hb, e_vb, e_ls, e_fs};
            got_v = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                     line_start_out, frame_start_out};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL scan k=%0d: got h=%0d v=%0d hs/vs/hb/vb/ls/fs=%b required h=%0d v=%0d %b",
                         k, hcount_out, vcount_out, got_v[5:0], eh, ev, exp_v[5:0]);
            end
            n_ls += int'(line_start_out);
            n_fs += int'(frame_start_out);
            tick();
        end
        checks++;
        if (frame_start_out !== 1'b1 || n_fs != 1) begin
            errors++;
            $display("FAIL frame_period: fs at %0d=%b, pulses in window=%0d required fs=1 pulses=1",
                     FRAME, frame_start_out, n_fs);
        end
        checks++;
        if (n_ls != VT) begin
            errors++;
            $display("FAIL line_count: got %0d required %0d", n_ls, VT);
        end
    endtask

    task automatic test_reset_mid_sync();
        int n;
        goto(22, 15);
        checks++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1 || hblnk_out !== 1'b1 || vblnk_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_sync_pre: hs=%b vs=%b hb=%b vb=%b required all 1",
                     hsync_out, vsync_out, hblnk_out, vblnk_out);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
             line_start_out, frame_start_out} !== 28'd0) begin
            errors++;
            $display("FAIL mid_sync_reset: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b required all 0",
                     hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                     line_start_out, frame_start_out);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (hcount_out !== 11'd1 || vcount_out !== 11'd0 || frame_start_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_sync_release: h=%0d v=%0d fs=%b required h=1 v=0 fs=0",
                     hcount_out, vcount_out, frame_start_out);
        end
        n = 0;
        while (frame_start_out !== 1'b1 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        checks++;
        if (n != FRAME - 1) begin
            errors++;
            $display("FAIL mid_sync_next_frame: cycles to frame_start=%0d required %0d", n, FRAME - 1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        test_reset();
        test_h_edges();
        test_line_wrap();
        test_frame_wrap();
        test_frame_period();
        test_reset_mid_sync();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 24, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 136, horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 160, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 3, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 29, vertical back porch in lines.
REQ-009 The block SHALL have port pclk, input, 1, pixel clock; it is the only clock.
REQ-010 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-011 The block SHALL have port hcount_out, output, 11, current pixel column.
REQ-012 The block SHALL have port vcount_out, output, 11, current line.
REQ-013 The block SHALL have port hsync_out, output, 1, horizontal sync, active-high.
REQ-014 The block SHALL have port vsync_out, output, 1, vertical sync, active-high.
REQ-015 The block SHALL have port hblnk_out, output, 1, horizontal blanking flag.
REQ-016 The block SHALL have port vblnk_out, output, 1, vertical blanking flag.
REQ-017 The block SHALL have port line_start_out, output, 1, one-cycle pulse on hcount wrap to 0.
REQ-018 The block SHALL have port frame_start_out, output, 1, one-cycle pulse on (hcount,vcount) wrap to (0,0).

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344), and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806); the block SHALL support both up to 2048 with 11-bit unsigned arithmetic.
REQ-020 All outputs SHALL be registered on pclk rising edge; no combinational path from inputs to outputs.
REQ-021 hcount_out SHALL increment by 1 each pclk, and SHALL load 0 on the edge after it equals H_TOTAL-1.
REQ-022 vcount_out SHALL change only on an hcount wrap: +1, or 0 if it equals V_TOTAL-1 at that wrap.
REQ-023 hblnk_out SHALL be 1 exactly when hcount_out >= H_ACTIVE (default 1024..1343).
REQ-024 hsync_out SHALL be 1 exactly when H_ACTIVE+H_FP <= hcount_out < H_ACTIVE+H_FP+H_SYNC (default 1048..1183).
REQ-025 vblnk_out SHALL be 1 exactly when vcount_out >= V_ACTIVE (default 768..805), for every hcount on those lines.
REQ-026 vsync_out SHALL be 1 exactly when V_ACTIVE+V_FP <= vcount_out < V_ACTIVE+V_FP+V_SYNC (default 771..776).
REQ-027 All flags SHALL be aligned with the counts shown in the same cycle: zero latency between the count value and its flags, which requires flags to be computed from next-count values.
REQ-028 line_start_out SHALL be 1 for exactly the one cycle in which hcount_out = 0 following an hcount wrap, and 0 otherwise.
REQ-029 frame_start_out SHALL be 1 for exactly the one cycle in which (hcount_out,vcount_out) = (0,0) following a wrap from (H_TOTAL-1,V_TOTAL-1), and 0 otherwise.
REQ-030 Simultaneous h and v wrap SHALL assert line_start_out and frame_start_out in the same cycle.
REQ-031 The first (0,0) after reset is not a wrap, so line_start_out and frame_start_out SHALL stay 0 in that cycle.

Reset
REQ-032 While rst=1 at a pclk edge, all outputs SHALL load 0: counts 0, all syncs/blanks 0, both pulses 0.
REQ-033 On the first edge with rst=0, hcount_out SHALL become 1 and vcount_out SHALL stay 0, and counting SHALL continue per REQ-021/022.
REQ-034 rst asserted mid-frame, including mid-sync or mid-blank, SHALL force REQ-032 values on the next edge with no residual pulse.

Verification
REQ-035 Reset scenario: hold rst 3 cycles, then release -> outputs all 0 during rst, then hcount sequence 1,2,3..., and vcount stays 0.
REQ-036 Horizontal edges scenario: on line 0, sample hcount 1023/1024, 1047/1048 and 1183/1184 -> hblnk 0->1, hsync 0->1, then hsync 1->0.
REQ-037 Line wrap scenario: on line 10, hcount 1343 -> next cycle hcount 0, vcount 11, line_start 1 for 1 cycle, frame_start 0.
REQ-038 Frame wrap scenario: at (1343,805) -> next cycle (0,0) with line_start=1, frame_start=1, vblnk 1->0 and vsync 0; vsync high exactly on lines 771..776.
REQ-039 Frame period scenario: count pclk cycles between consecutive frame_start pulses -> exactly 1,083,264 (1344x806), with 806 line_start pulses per frame.
REQ-040 Reset mid-sync scenario: assert rst at hcount 1100 on line 773 -> next cycle all outputs 0, and no frame_start until one full frame later.
